// File: rtl/axi4_lite_pkg.sv
// Shared types and defaults for the 4-bit AXI-lite master, its responder and benches.
package axi4_lite_pkg;
   localparam int ADDR_W_DEF  = 4;
   localparam int DATA_W_DEF  = 4;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_DATA,
      RESP
   } state_t;
endpackage

// File: rtl/axi_hs_timeout.sv
// Handshake wait counter: cleared while idle or on a phase change, counts wait cycles,
// flags expiry on the cycle whose edge would complete TIMEOUT waits.
module axi_hs_timeout
   import axi4_lite_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   // A clear in the same cycle means the phase completed, which takes priority over expiry.
   assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/axi4_lite_master_4b.sv
// One-outstanding AXI-lite master: turns single host commands into AW/W or AR/R handshakes
// and returns one response pulse per command, with a timeout abort.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a host command
// WR      | AW and W valids pending, each dropped on its own handshake
// RD_ADDR | ms_arvalid high, waiting for sm_arready
// RD_DATA | ms_rready high, waiting for sm_rvalid
// RESP    | result latched; rsp_valid pulses on the following cycle
module axi4_lite_master_4b
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              ms_awvalid,
   input  logic              sm_awready,
   output logic              ms_wvalid,
   output logic [DATA_W-1:0] SWM_wdata,
   input  logic              sm_wready,
   output logic              ms_arvalid,
   output logic [ADDR_W-1:0] SWM_arADDR,
   input  logic              sm_arready,
   output logic              ms_rready,
   input  logic              sm_rvalid,
   input  logic [DATA_W-1:0] sm_rdata
);
   state_t state;
   logic   aw_done, w_done;
   logic   aw_fire, w_fire, ar_fire, r_fire;
   logic   aw_done_n, w_done_n;
   logic   to_clear, to_enable, to_expired;

   assign aw_fire   = ms_awvalid & sm_awready;
   assign w_fire    = ms_wvalid & sm_wready;
   assign ar_fire   = ms_arvalid & sm_arready;
   assign r_fire    = ms_rready & sm_rvalid;
   assign aw_done_n = aw_done | aw_fire;
   assign w_done_n  = w_done | w_fire;

   assign to_enable = (state == WR) || (state == RD_ADDR) || (state == RD_DATA);
   // Restart the wait budget when the read moves from the address to the data phase.
   assign to_clear  = !to_enable || ar_fire;

   axi_hs_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (to_clear),
      .enable  (to_enable),
      .expired (to_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         ms_awvalid <= 1'b0;
         ms_wvalid  <= 1'b0;
         ms_arvalid <= 1'b0;
         ms_rready  <= 1'b0;
         SWM_arADDR <= '0;
         SWM_wdata  <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready  <= 1'b0;
                  SWM_arADDR <= cmd_addr;
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
                  if (cmd_we) begin
                     SWM_wdata  <= cmd_wdata;
                     ms_awvalid <= 1'b1;
                     ms_wvalid  <= 1'b1;
                     state      <= WR;
                  end else begin
                     ms_arvalid <= 1'b1;
                     state      <= RD_ADDR;
                  end
               end
            end
            WR: begin
               if (aw_fire) ms_awvalid <= 1'b0;
               if (w_fire)  ms_wvalid  <= 1'b0;
               aw_done <= aw_done_n;
               w_done  <= w_done_n;
               if (aw_done_n && w_done_n) begin
                  rsp_err   <= 1'b0;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end else if (to_expired) begin
                  ms_awvalid <= 1'b0;
                  ms_wvalid  <= 1'b0;
                  rsp_err    <= 1'b1;
                  rsp_rdata  <= '0;
                  state      <= RESP;
               end
            end
            RD_ADDR: begin
               if (ar_fire) begin
                  ms_arvalid <= 1'b0;
                  ms_rready  <= 1'b1;
                  state      <= RD_DATA;
               end else if (to_expired) begin
                  ms_arvalid <= 1'b0;
                  rsp_err    <= 1'b1;
                  rsp_rdata  <= '0;
                  state      <= RESP;
               end
            end
            RD_DATA: begin
               if (r_fire) begin
                  ms_rready <= 1'b0;
                  rsp_rdata <= sm_rdata;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end else if (to_expired) begin
                  ms_rready <= 1'b0;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_lite_master_4b.sv
// Directed bench for axi4_lite_master_4b: table of transactions against a latency-programmable
// responder, plus reset-mid-write and back-to-back command sequences.
module tb_axi4_lite_master_4b;
   import axi4_lite_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready, cmd_we;
   logic [3:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err;
   logic [3:0] rsp_rdata;
   logic       ms_awvalid, sm_awready, ms_wvalid, sm_wready;
   logic       ms_arvalid, sm_arready, ms_rready, sm_rvalid;
   logic [3:0] SWM_wdata, SWM_arADDR, sm_rdata;

   axi4_lite_master_4b #(.ADDR_W(4), .DATA_W(4), .TIMEOUT(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .ms_awvalid (ms_awvalid),
      .sm_awready (sm_awready),
      .ms_wvalid  (ms_wvalid),
      .SWM_wdata  (SWM_wdata),
      .sm_wready  (sm_wready),
      .ms_arvalid (ms_arvalid),
      .SWM_arADDR (SWM_arADDR),
      .sm_arready (sm_arready),
      .ms_rready  (ms_rready),
      .sm_rvalid  (sm_rvalid),
      .sm_rdata   (sm_rdata)
   );

   always #5 clk = ~clk;

   // lat1: AW (write) or AR (read) ready delay; lat2: W ready or R valid delay; 99 = never.
   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [3:0] wdata;
      int         lat1;
      int         lat2;
      logic [3:0] rdin;
      int         exp_c;
      logic       exp_err;
      logic [3:0] exp_rdata;
      int         exp_hi1;
      int         exp_hi2;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_readies();
      sm_awready = 1'b0;
      sm_wready  = 1'b0;
      sm_arready = 1'b0;
      sm_rvalid  = 1'b0;
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int c, h1, h2, got_c;
      logic stab_ok, err_s, crdy_s;
      logic [3:0] rd_s;
      check({tag, "_cmd_ready_before"}, int'(cmd_ready), 1);
      cmd_valid  = 1'b1;
      cmd_we     = v.we;
      cmd_addr   = v.addr;
      cmd_wdata  = v.wdata;
      sm_rdata   = v.rdin;
      sm_awready = v.we && (v.lat1 == 0);
      sm_wready  = v.we && (v.lat2 == 0);
      sm_arready = !v.we && (v.lat1 == 0);
      sm_rvalid  = 1'b0;
      step();
      cmd_valid = 1'b0;
      c = 0; h1 = 0; h2 = 0; got_c = -1;
      stab_ok = 1'b1; err_s = 1'b0; crdy_s = 1'b0; rd_s = 4'h0;
      while (got_c < 0 && c < 40) begin
         if (rsp_valid) begin
            got_c  = c;
            err_s  = rsp_err;
            rd_s   = rsp_rdata;
            crdy_s = cmd_ready;
         end else begin
            if (v.we) begin
               if (ms_awvalid) h1++;
               if (ms_wvalid) h2++;
               if ((ms_awvalid || ms_wvalid) && (SWM_arADDR != v.addr || SWM_wdata != v.wdata))
                  stab_ok = 1'b0;
               sm_awready = ms_awvalid && (h1 > v.lat1);
               sm_wready  = ms_wvalid && (h2 > v.lat2);
            end else begin
               if (ms_arvalid) h1++;
               if (ms_rready) h2++;
               if ((ms_arvalid || ms_rready) && SWM_arADDR != v.addr) stab_ok = 1'b0;
               sm_arready = ms_arvalid && (h1 > v.lat1);
               sm_rvalid  = ms_rready && (h2 > v.lat2);
            end
            step();
            c++;
         end
      end
      idle_readies();
      check({tag, "_rsp_cycle"}, got_c, v.exp_c);
      check({tag, "_rsp_err"}, int'(err_s), int'(v.exp_err));
      check({tag, "_rsp_rdata"}, int'(rd_s), int'(v.exp_rdata));
      check({tag, "_cmd_ready_in_rsp"}, int'(crdy_s), 0);
      check({tag, "_valid1_cycles"}, h1, v.exp_hi1);
      check({tag, "_valid2_cycles"}, h2, v.exp_hi2);
      check({tag, "_bus_stable"}, int'(stab_ok), 1);
      step();
      check({tag, "_rsp_one_cycle"}, int'(rsp_valid), 0);
      check({tag, "_cmd_ready_after"}, int'(cmd_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[11];
      vec_t rd_after;
      int acc_c[2], rsp_c[2], na, nr, ar_first, rsp_seen;
      logic [3:0] rsp_d[2];
      logic accept_now;

      vecs[0]  = '{1'b1, 4'h2, 4'h4,  0,  0, 4'hF,  2, 1'b0, 4'h0,  1,  1};
      vecs[1]  = '{1'b1, 4'h5, 4'hA,  0,  3, 4'hF,  5, 1'b0, 4'h0,  1,  4};
      vecs[2]  = '{1'b1, 4'h7, 4'h1,  2,  0, 4'h3,  4, 1'b0, 4'h0,  3,  1};
      vecs[3]  = '{1'b0, 4'h2, 4'h0,  0,  3, 4'h4,  6, 1'b0, 4'h4,  1,  4};
      vecs[4]  = '{1'b0, 4'h9, 4'h0,  0,  0, 4'hC,  3, 1'b0, 4'hC,  1,  1};
      vecs[5]  = '{1'b0, 4'h2, 4'h0, 99,  0, 4'h5, 16, 1'b1, 4'h0, 15,  0};
      vecs[6]  = '{1'b1, 4'h3, 4'h6, 99,  0, 4'h5, 16, 1'b1, 4'h0, 15,  1};
      vecs[7]  = '{1'b1, 4'h1, 4'h2, 14,  0, 4'h5, 16, 1'b0, 4'h0, 15,  1};
      vecs[8]  = '{1'b0, 4'h4, 4'h0,  0, 99, 4'h8, 17, 1'b1, 4'h0,  1, 15};
      vecs[9]  = '{1'b0, 4'h6, 4'h0, 14,  0, 4'h7, 17, 1'b0, 4'h7, 15,  1};
      vecs[10] = '{1'b1, 4'hE, 4'hF, 15, 15, 4'h1, 16, 1'b1, 4'h0, 15, 15};

      reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 4'h0; cmd_wdata = 4'h0;
      sm_rdata = 4'h0;
      idle_readies();
      step();
      step();
      check("reset_cmd_ready", int'(cmd_ready), 1);
      check("reset_rsp_valid", int'(rsp_valid), 0);
      check("reset_rsp_err", int'(rsp_err), 0);
      check("reset_rsp_rdata", int'(rsp_rdata), 0);
      check("reset_valids", int'({ms_awvalid, ms_wvalid, ms_arvalid, ms_rready}), 0);
      check("reset_arADDR", int'(SWM_arADDR), 0);
      check("reset_wdata", int'(SWM_wdata), 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Reset while the write data phase is stalled.
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'hB; cmd_wdata = 4'h5;
      sm_awready = 1'b1; sm_wready = 1'b0;
      step();
      cmd_valid = 1'b0;
      step();
      step();
      check("rst_mid_wvalid_pending", int'(ms_wvalid), 1);
      reset = 1'b1;
      step();
      check("rst_mid_valids", int'({ms_awvalid, ms_wvalid, ms_arvalid, ms_rready}), 0);
      check("rst_mid_rsp_valid", int'(rsp_valid), 0);
      check("rst_mid_cmd_ready", int'(cmd_ready), 1);
      check("rst_mid_arADDR", int'(SWM_arADDR), 0);
      reset = 1'b0;
      idle_readies();
      rsp_seen = 0;
      for (int k = 0; k < 5; k++) begin
         if (rsp_valid) rsp_seen++;
         step();
      end
      check("rst_mid_no_rsp", rsp_seen, 0);
      rd_after = '{1'b0, 4'h2, 4'h0, 0, 0, 4'h4, 3, 1'b0, 4'h4, 1, 1};
      run_txn(rd_after, "rd_after_rst");

      // Back-to-back: cmd_valid held, responder always ready, write then read.
      sm_awready = 1'b1; sm_wready = 1'b1; sm_arready = 1'b1; sm_rvalid = 1'b1; sm_rdata = 4'h9;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h3; cmd_wdata = 4'h9;
      acc_c[0] = -1; acc_c[1] = -1; rsp_c[0] = -1; rsp_c[1] = -1;
      rsp_d[0] = 4'hF; rsp_d[1] = 4'hF;
      na = 0; nr = 0; ar_first = -1;
      for (int c = 0; c < 20 && nr < 2; c++) begin
         if (rsp_valid) begin
            rsp_c[nr] = c;
            rsp_d[nr] = rsp_rdata;
            nr++;
         end
         if (ms_arvalid && ar_first < 0) ar_first = c;
         accept_now = cmd_valid && cmd_ready;
         if (accept_now && na < 2) acc_c[na] = c;
         step();
         if (accept_now) begin
            na++;
            if (na == 1) begin
               cmd_we = 1'b0; cmd_addr = 4'h3;
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      cmd_valid = 1'b0;
      idle_readies();
      check("b2b_accepts", na, 2);
      check("b2b_rsps", nr, 2);
      check("b2b_accept0", acc_c[0], 0);
      check("b2b_rsp0_cycle", rsp_c[0], 3);
      check("b2b_rsp0_rdata", int'(rsp_d[0]), 0);
      check("b2b_accept1", acc_c[1], 4);
      check("b2b_arvalid_first", ar_first, 5);
      check("b2b_rsp1_cycle", rsp_c[1], 8);
      check("b2b_rsp1_rdata", int'(rsp_d[1]), 9);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
